// File: rtl/mini_alu_pipe_if.sv
// ----------------------------------------------------------------------------
// mini_alu_pipe_if
//   Bundles the operation request and result handshakes of mini_alu_pipe.
//   Instantiate with the same WIDTH as the mini_alu_pipe it connects to.
//
//   Request side : in_valid, in_ready, fxn_code[2:0], a[WIDTH-1:0], b[WIDTH-1:0]
//   Result side  : out_valid, out_ready, result[WIDTH-1:0], ovf
//   Status       : acc[WIDTH-1:0] (current accumulator)
//
//   Modports: master = operation source / result sink, slave = the ALU.
// ----------------------------------------------------------------------------
interface mini_alu_pipe_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       fxn_code;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, fxn_code, a, b, out_ready,
        input  in_ready, out_valid, result, ovf, acc
    );

    modport slave (
        input  in_valid, fxn_code, a, b, out_ready,
        output in_ready, out_valid, result, ovf, acc
    );
endinterface

// File: rtl/mini_alu_pipe.sv
// ----------------------------------------------------------------------------
// mini_alu_pipe
//   Two-stage signed ALU with an accumulator.
//   S1 captures {fxn_code, a, b} on accept; S2 computes and registers
//   {result, ovf}. The accumulator changes only when a 110/111 op moves
//   S1 -> S2.
//
//   fxn_code: 000 a | 001 b | 010 a+b | 011 a-b | 100 a^b
//             101 (a>b signed) zero-extended | 110 acc+a, acc<=result
//             111 result=acc, acc<=0
//
//   Ports:
//     clk   - single clock, rising edge
//     reset - asynchronous, active-high; discards everything in flight
//     bus   - mini_alu_pipe_if.slave (request, result, acc)
//
//   Parameter WIDTH (4..32, default 6) must match the interface WIDTH.
//
//   Compile option MINI_ALU_SAT_EN: when defined, 010/011/110 clamp to the
//   signed range instead of wrapping; ovf still reports the clamp. When
//   undefined, arithmetic wraps modulo 2^WIDTH.
// ----------------------------------------------------------------------------
module mini_alu_pipe #(
    parameter int WIDTH = 6
) (
    input logic            clk,
    input logic            reset,
    mini_alu_pipe_if.slave bus
);
    localparam logic [2:0] OP_A   = 3'b000;
    localparam logic [2:0] OP_B   = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_GT  = 3'b101;
    localparam logic [2:0] OP_ACC = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

`ifdef MINI_ALU_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Stage 1: captured operation
    logic             r_s1_valid;
    logic [2:0]       r_s1_code;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    // Stage 2: registered result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_ovf;

    logic [WIDTH-1:0] r_acc;

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both 1. The source must hold its payload while valid=1 and
    // ready=0; ready may depend combinationally on out_ready.
    logic w_advance;
    logic w_in_ready;
    logic w_accept;

    // Arithmetic is done one bit wider; the two top bits disagree exactly
    // when the true signed result does not fit in WIDTH bits.
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_acc_sum;
    logic             w_sum_ovf;
    logic             w_diff_ovf;
    logic             w_acc_ovf;
    logic [WIDTH-1:0] w_sum_res;
    logic [WIDTH-1:0] w_diff_res;
    logic [WIDTH-1:0] w_acc_res;
    logic             w_gt;

    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_next;

    // S2 can take a new value when it is empty or its result leaves now.
    assign w_advance  = !r_s2_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_advance;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_sum     = {r_s1_a[WIDTH-1], r_s1_a} + {r_s1_b[WIDTH-1], r_s1_b};
    assign w_diff    = {r_s1_a[WIDTH-1], r_s1_a} - {r_s1_b[WIDTH-1], r_s1_b};
    assign w_acc_sum = {r_acc[WIDTH-1], r_acc} + {r_s1_a[WIDTH-1], r_s1_a};

    assign w_sum_ovf  = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    assign w_diff_ovf = w_diff[WIDTH] ^ w_diff[WIDTH-1];
    assign w_acc_ovf  = w_acc_sum[WIDTH] ^ w_acc_sum[WIDTH-1];

`ifdef MINI_ALU_SAT_EN
    // On overflow the wide result's top bit carries the true sign, which
    // picks the rail to clamp to.
    assign w_sum_res  = w_sum_ovf  ? (w_sum[WIDTH]     ? MAX_NEG : MAX_POS) : w_sum[WIDTH-1:0];
    assign w_diff_res = w_diff_ovf ? (w_diff[WIDTH]    ? MAX_NEG : MAX_POS) : w_diff[WIDTH-1:0];
    assign w_acc_res  = w_acc_ovf  ? (w_acc_sum[WIDTH] ? MAX_NEG : MAX_POS) : w_acc_sum[WIDTH-1:0];
`else
    assign w_sum_res  = w_sum[WIDTH-1:0];
    assign w_diff_res = w_diff[WIDTH-1:0];
    assign w_acc_res  = w_acc_sum[WIDTH-1:0];
`endif

    assign w_gt = $signed(r_s1_a) > $signed(r_s1_b);

    always_comb begin
        w_res      = '0;
        w_ovf      = 1'b0;
        w_acc_next = r_acc;
        case (r_s1_code)
            OP_A:   w_res = r_s1_a;
            OP_B:   w_res = r_s1_b;
            OP_ADD: begin
                w_res = w_sum_res;
                w_ovf = w_sum_ovf;
            end
            OP_SUB: begin
                w_res = w_diff_res;
                w_ovf = w_diff_ovf;
            end
            OP_XOR: w_res = r_s1_a ^ r_s1_b;
            OP_GT:  w_res = {{(WIDTH-1){1'b0}}, w_gt};
            OP_ACC: begin
                w_res      = w_acc_res;
                w_ovf      = w_acc_ovf;
                w_acc_next = w_acc_res;
            end
            OP_CLR: begin
                w_res      = r_acc;
                w_acc_next = '0;
            end
            default: w_res = '0;
        endcase
    end

    // Stage 2 and accumulator. When S2 drains with S1 empty, result/ovf keep
    // their last value and only out_valid falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_acc      <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
                r_acc    <= w_acc_next;
            end
        end
    end

    // Stage 1: reloads whenever it is free or being emptied into S2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_code <= bus.fxn_code;
                r_s1_a    <= bus.a;
                r_s1_b    <= bus.b;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.result    = r_result;
    assign bus.ovf       = r_ovf;
    assign bus.acc       = r_acc;

endmodule
